// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 master.
package spi_pkg;

  localparam int MAX_BITS_DEF = 16;
  localparam int DIV_W_DEF    = 8;

  // Line levels while no transfer is in progress
  localparam logic SCK_IDLE = 1'b0;
  localparam logic SS_IDLE  = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    TRAIL = 3'd4,
    DONE  = 3'd5
  } spi_state_e;

endpackage

// File: rtl/spi_clkdiv.sv
// Loadable down-counter that times each SPI phase; tick marks the last cycle of a phase.
module spi_clkdiv #(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] value,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;

  // Reload on request, otherwise count down and park at zero (never wraps by itself)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - DIV_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign tick = (r_cnt == '0);

endmodule

// File: rtl/spi_master_lite.sv
// SPI mode-0 master, MSB first, single slave select, start/done command interface.
// Phase sequence per transfer: LEAD (D), N x HIGH (D), N-1 x LOW (D), TRAIL (2D, the
// final LOW merged with the hold time), then one DONE cycle. All outputs are registered
// from the next-state decode so they change exactly with the state.
module spi_master_lite
  import spi_pkg::*;
#(
  parameter  int MAX_BITS = MAX_BITS_DEF,
  parameter  int DIV_W    = DIV_W_DEF,
  localparam int LEN_W    = $clog2(MAX_BITS + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [MAX_BITS-1:0] tx_data,
  input  logic [LEN_W-1:0]    len,
  input  logic [DIV_W-1:0]    div,
  output logic                busy,
  output logic                done,
  output logic [MAX_BITS-1:0] rx_data,
  output logic                sck,
  output logic                ss,
  output logic                mosi,
  input  logic                miso
);

  spi_state_e          r_state;
  spi_state_e          w_next;
  logic [DIV_W-1:0]    r_dm1;
  logic [DIV_W-1:0]    w_div_eff;
  logic [DIV_W-1:0]    w_load_val;
  logic                w_load;
  logic                w_trail_reload;
  logic                w_tick;
  logic                w_accept;
  logic                w_enter_high;
  logic                w_enter_low;
  logic                w_active_next;
  logic                r_trail2;
  logic [LEN_W-1:0]    r_bits;
  logic [MAX_BITS-1:0] r_tx;
  logic [MAX_BITS-1:0] r_rx;

  assign w_accept     = (r_state == IDLE) && start;
  assign w_enter_high = (w_next == HIGH) && (r_state != HIGH);
  assign w_enter_low  = (w_next == LOW) && (r_state != LOW);
  assign w_load       = (w_next != r_state) || w_trail_reload;

  // Effective half period: a divider of 0 behaves as 1
  always_comb begin
    w_div_eff = div;
    if (div == '0) begin
      w_div_eff = DIV_W'(1);
    end else begin
      w_div_eff = div;
    end
  end

  // Counter reload value: taken from the live input at accept, from the latched copy afterwards
  always_comb begin
    w_load_val = r_dm1;
    if (r_state == IDLE) begin
      w_load_val = w_div_eff - DIV_W'(1);
    end else begin
      w_load_val = r_dm1;
    end
  end

  spi_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
    .clock (clock),
    .reset (reset),
    .load  (w_load),
    .value (w_load_val),
    .tick  (w_tick)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; TRAIL runs two divider periods via an extra reload
  always_comb begin
    w_next         = r_state;
    w_trail_reload = 1'b0;
    w_active_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            w_next = LEAD;
          end else begin
            w_next = DONE;
          end
        end else begin
          w_next = IDLE;
        end
      end
      LEAD: begin
        if (w_tick) w_next = HIGH;
        else        w_next = LEAD;
      end
      HIGH: begin
        if (w_tick) begin
          if (r_bits > LEN_W'(1)) w_next = LOW;
          else                    w_next = TRAIL;
        end else begin
          w_next = HIGH;
        end
      end
      LOW: begin
        if (w_tick) begin
          if (r_bits != '0) w_next = HIGH;
          else              w_next = TRAIL;
        end else begin
          w_next = LOW;
        end
      end
      TRAIL: begin
        if (w_tick) begin
          if (r_trail2) begin
            w_next = DONE;
          end else begin
            w_next         = TRAIL;
            w_trail_reload = 1'b1;
          end
        end else begin
          w_next = TRAIL;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    w_active_next = (w_next == LEAD) || (w_next == HIGH) ||
                    (w_next == LOW)  || (w_next == TRAIL);
  end

  // Datapath: latch command on accept, shift tx on LOW entry, capture miso on HIGH entry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dm1    <= '0;
      r_bits   <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_trail2 <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dm1  <= w_div_eff - DIV_W'(1);
        r_bits <= len;
        r_tx   <= tx_data;
        r_rx   <= '0;
      end else begin
        if (w_enter_low) begin
          r_bits <= r_bits - LEN_W'(1);
          r_tx   <= r_tx << 1;
        end
        if (w_enter_high) begin
          r_rx <= {r_rx[MAX_BITS-2:0], miso};
        end
      end
      if (r_state != TRAIL) begin
        r_trail2 <= 1'b0;
      end else if (w_tick) begin
        r_trail2 <= 1'b1;
      end
    end
  end

  // Registered interface outputs decoded from the next state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      sck     <= SCK_IDLE;
      ss      <= SS_IDLE;
      mosi    <= 1'b1;
    end else begin
      busy <= (w_next != IDLE);
      done <= (w_next == DONE);
      sck  <= (w_next == HIGH);
      ss   <= ~w_active_next;
      if (w_next == DONE) begin
        if (w_accept) rx_data <= '0;
        else          rx_data <= r_rx;
      end
      if (w_accept && (w_next == LEAD)) begin
        mosi <= tx_data[MAX_BITS-1];
      end else if (w_enter_low) begin
        mosi <= r_tx[MAX_BITS-2];
      end else if (!w_active_next) begin
        mosi <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_lite.sv
// Directed self-checking bench for spi_master_lite.
// Cycle k=1 is the first cycle after the edge that accepts start; done is expected
// at k = 2*D*(N+1) + 1, and ss is low for exactly k = 1 .. 2*D*(N+1).
module tb_spi_master_lite;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] tx_data = 16'h0000;
  logic [4:0]  len = 5'd0;
  logic [7:0]  div = 8'd1;
  logic        busy, done, sck, ss, mosi, miso;
  logic [15:0] rx_data;
  logic        loop_en = 1'b0;
  logic        miso_fix = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  int          res_lat, res_rises, res_ss_low, res_done_cnt;
  int          hi_min, hi_max, lo_min, lo_max;
  logic        res_busy_at_done;
  logic [15:0] res_rx;
  logic [191:0] res_trace;

  assign miso = loop_en ? mosi : miso_fix;

  always #5 clock = ~clock;

  spi_master_lite dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .tx_data (tx_data),
    .len     (len),
    .div     (div),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .sck     (sck),
    .ss      (ss),
    .mosi    (mosi),
    .miso    (miso)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer starting at posedge+1; optional start re-pulse at cycle repulse_k
  // and optional asynchronous reset during the HIGH phase after rising edge abort_rise.
  task automatic run_xfer(input logic [15:0] tx, input logic [4:0] l, input logic [7:0] d,
                          input logic lb, input logic mf, input int repulse_k, input int abort_rise);
    int   k, cur_run;
    logic prev_sck, seen_fall, fin;
    res_lat = 0; res_rises = 0; res_ss_low = 0; res_done_cnt = 0;
    hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
    res_trace = '0; res_rx = 16'h0; res_busy_at_done = 1'b0;
    prev_sck = 1'b0; seen_fall = 1'b0; cur_run = 0; fin = 1'b0;
    loop_en = lb; miso_fix = mf;
    tx_data = tx; len = l; div = d; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    k = 1;
    while (!fin) begin
      if (repulse_k != 0 && k == repulse_k) begin
        start = 1'b1; tx_data = 16'hFFFF; len = 5'd16; div = 8'd5;
      end else if (repulse_k != 0 && k == repulse_k + 1) begin
        start = 1'b0;
      end
      if (k <= 64) res_trace[3*(k-1) +: 3] = {sck, ss, mosi};
      if (!ss) res_ss_low++;
      if (sck != prev_sck) begin
        if (prev_sck) begin
          if (cur_run < hi_min) hi_min = cur_run;
          if (cur_run > hi_max) hi_max = cur_run;
          seen_fall = 1'b1;
        end else begin
          res_rises++;
          if (seen_fall) begin
            if (cur_run < lo_min) lo_min = cur_run;
            if (cur_run > lo_max) lo_max = cur_run;
          end
        end
        cur_run = 1;
      end else begin
        cur_run++;
      end
      prev_sck = sck;
      if (abort_rise != 0 && sck && res_rises == abort_rise && cur_run == 1) begin
        #2 reset = 1'b1;
        #1;
        check_eq("abort_sck", {31'd0, sck}, 32'd0);
        check_eq("abort_ss", {31'd0, ss}, 32'd1);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
          @(posedge clock); #1;
          if (done) res_done_cnt++;
        end
        reset = 1'b0;
        fin = 1'b1;
      end else if (done) begin
        res_done_cnt++;
        res_lat = k;
        res_rx = rx_data;
        res_busy_at_done = busy;
        fin = 1'b1;
      end else if (k >= 2000) begin
        check_eq("timeout", 32'd0, 32'd1);
        fin = 1'b1;
      end else begin
        @(posedge clock); #1;
        k++;
      end
    end
    start = 1'b0;
  endtask

  logic [191:0] trace_d0;
  int           idle_ss_low;

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_rx", {16'd0, rx_data}, 32'd0);
    check_eq("rst_sck", {31'd0, sck}, 32'd0);
    check_eq("rst_ss", {31'd0, ss}, 32'd1);
    check_eq("rst_mosi", {31'd0, mosi}, 32'd1);
    reset = 1'b0;
    @(posedge clock); #1;

    // 1: loopback, 16 bits, D=1
    run_xfer(16'hA55A, 5'd16, 8'd1, 1'b1, 1'b0, 0, 0);
    check_eq("t1_rx", {16'd0, res_rx}, 32'h0000A55A);
    check_eq("t1_lat", res_lat, 32'd35);
    check_eq("t1_rises", res_rises, 32'd16);
    check_eq("t1_busy_at_done", {31'd0, res_busy_at_done}, 32'd1);
    @(posedge clock); #1;
    check_eq("t1_done_pulse", {31'd0, done}, 32'd0);
    check_eq("t1_busy_after", {31'd0, busy}, 32'd0);

    // 2: miso tied high, 8 bits, D=3
    run_xfer(16'h0000, 5'd8, 8'd3, 1'b0, 1'b1, 0, 0);
    check_eq("t2_rx", {16'd0, res_rx}, 32'h000000FF);
    check_eq("t2_lat", res_lat, 32'd55);
    check_eq("t2_ss_low", res_ss_low, 32'd54);
    check_eq("t2_rises", res_rises, 32'd8);
    check_eq("t2_hi_min", hi_min, 32'd3);
    check_eq("t2_hi_max", hi_max, 32'd3);
    check_eq("t2_lo_min", lo_min, 32'd3);
    check_eq("t2_lo_max", lo_max, 32'd3);
    @(posedge clock); #1;

    // 3: zero-length transfer clears rx_data, no sck activity, ss stays high
    run_xfer(16'hFFFF, 5'd0, 8'd4, 1'b0, 1'b1, 0, 0);
    check_eq("t3_lat", res_lat, 32'd1);
    check_eq("t3_rx", {16'd0, res_rx}, 32'd0);
    check_eq("t3_rises", res_rises, 32'd0);
    check_eq("t3_ss_low", res_ss_low, 32'd0);
    @(posedge clock); #1;

    // 4: div=0 must behave exactly like div=1
    run_xfer(16'hC000, 5'd4, 8'd0, 1'b1, 1'b0, 0, 0);
    trace_d0 = res_trace;
    check_eq("t4_d0_rx", {16'd0, res_rx}, 32'h0000000C);
    check_eq("t4_d0_lat", res_lat, 32'd11);
    @(posedge clock); #1;
    run_xfer(16'hC000, 5'd4, 8'd1, 1'b1, 1'b0, 0, 0);
    check_eq("t4_d1_rx", {16'd0, res_rx}, 32'h0000000C);
    check_eq("t4_d1_lat", res_lat, 32'd11);
    check_eq("t4_wave_eq", {31'd0, (trace_d0 == res_trace)}, 32'd1);
    @(posedge clock); #1;

    // 5: start re-pulsed while busy is ignored
    run_xfer(16'h9600, 5'd8, 8'd2, 1'b1, 1'b0, 10, 0);
    check_eq("t5_rx", {16'd0, res_rx}, 32'h00000096);
    check_eq("t5_lat", res_lat, 32'd37);
    check_eq("t5_rises", res_rises, 32'd8);
    idle_ss_low = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (!ss || busy) idle_ss_low++;
    end
    check_eq("t5_no_restart", idle_ss_low, 32'd0);

    // 6: reset during HIGH of bit 5, then a clean transfer
    run_xfer(16'h3C00, 5'd8, 8'd2, 1'b0, 1'b0, 0, 5);
    check_eq("t6_no_done", res_done_cnt, 32'd0);
    check_eq("t6_rx_cleared", {16'd0, rx_data}, 32'd0);
    @(posedge clock); #1;
    run_xfer(16'h5A00, 5'd8, 8'd2, 1'b1, 1'b0, 0, 0);
    check_eq("t6_clean_rx", {16'd0, res_rx}, 32'h0000005A);
    check_eq("t6_clean_lat", res_lat, 32'd37);
    check_eq("t6_clean_rises", res_rises, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
